// File: rtl/uart_pkg.sv
// Shared types for the UART transmit arbiter: FSM state encoding and byte width.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at/after ptr (wrapping) that is
// both requesting and enabled by mask wins.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic [NUM_REQ-1:0] mask,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    idx
);

  logic found;
  int   j;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(ptr) + k) % NUM_REQ;
      if (!found && req[j] && mask[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = ID_W'(j);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among NUM_REQ byte sources.
// Define UART_ARB_BURST_EN to keep the grant on one requester until it sends req_last.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [UART_DATA_W*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]             req_last,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           tx_start,
  output logic [UART_DATA_W-1:0]         tx_data,
  input  logic                           tx_busy,
  output logic [ID_W-1:0]                grant_id,
  output logic                           arb_busy
);

  arb_state_t state, state_nxt;

  logic [NUM_REQ-1:0][UART_DATA_W-1:0] data_arr;
  logic [NUM_REQ-1:0]                  win_gnt;
  logic [NUM_REQ-1:0]                  mask;
  logic [ID_W-1:0]                     win_idx;
  logic [ID_W-1:0]                     ptr;
  logic [ID_W-1:0]                     ptr_nxt;
  logic                                accept;
  logic                                lock;
  logic                                done;

  assign data_arr = req_data;
  assign accept   = |req_ready;
  assign done     = (state == WAIT_DONE) && !tx_busy;
  assign ptr_nxt  = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req  (req_valid),
    .ptr  (ptr),
    .mask (mask),
    .gnt  (win_gnt),
    .idx  (win_idx)
  );

`ifdef UART_ARB_BURST_EN
  // Lock follows the last accepted byte: a non-final byte pins the grant to its owner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      lock <= 1'b0;
    else if (accept) lock <= !req_last[win_idx];
  end

  always_comb begin
    mask = '1;
    if (lock) mask = NUM_REQ'(1) << grant_id;
  end
`else
  logic unused_last;
  assign unused_last = ^req_last;
  assign lock        = 1'b0;
  assign mask        = '1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (accept)   state_nxt = LAUNCH;
      LAUNCH:                  state_nxt = WAIT_BUSY;
      WAIT_BUSY: if (tx_busy)  state_nxt = WAIT_DONE;
      WAIT_DONE: if (!tx_busy) state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  // rst_n gates ready so nothing is offered while reset is held.
  always_comb begin
    req_ready = '0;
    if (rst_n && state == IDLE && !tx_busy) req_ready = win_gnt;
    tx_start = (state == LAUNCH);
    arb_busy = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_data  <= '0;
      grant_id <= '0;
      ptr      <= '0;
    end else begin
      if (accept) begin
        tx_data  <= data_arr[win_idx];
        grant_id <= win_idx;
      end
      if (done && !lock) ptr <= ptr_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a simple uart_tx busy model.
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int N  = 4;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_last = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   req_ready;
  logic           tx_start;
  logic [7:0]     tx_data;
  logic           tx_busy;
  logic [IW-1:0]  grant_id;
  logic           arb_busy;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_busy   (tx_busy),
    .grant_id  (grant_id),
    .arb_busy  (arb_busy)
  );

  // uart_tx model: busy rises the cycle after tx_start and holds for 20 cycles
  int busy_cnt = 0;
  always @(posedge clk) begin
    if (tx_start)           busy_cnt <= 20;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0);

  logic [8:0] src_q [N][$];
  logic [9:0] exp_q [$];
  int         n_chk  = 0;
  int         n_pass = 0;
  bit         drv_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_chk++;
    if (obs === want) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, want);
  endtask

  task automatic send(input int id, input logic [7:0] d, input bit last);
    src_q[id].push_back({last, d});
  endtask

  task automatic sb_push(input int id, input logic [7:0] d);
    exp_q.push_back({2'(id), d});
  endtask

  function automatic bit pending();
    bit p = (req_valid != '0);
    for (int i = 0; i < N; i++) if (src_q[i].size() != 0) p = 1'b1;
    return p;
  endfunction

  task automatic drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || arb_busy || pending()) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(n < 2000), 1);
  endtask

  // Requester driver: a byte leaves its source queue once its handshake completes.
  initial begin
    logic [N-1:0] fire;
    wait (drv_en);
    forever begin
      @(negedge clk);
      fire = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (fire[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
        if (src_q[i].size() != 0) begin
          req_valid[i]       = 1'b1;
          req_data[8*i +: 8] = src_q[i][0][7:0];
          req_last[i]        = src_q[i][0][8];
        end else begin
          req_valid[i] = 1'b0;
        end
      end
    end
  end

  // Monitor: every launch must match the scoreboard head.
  initial begin
    bit         fprev = 1'b0;
    logic [9:0] e;
    logic [7:0] launched = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (fprev) chk("launch_latency", 32'(tx_start), 1);
        if (req_ready != '0) chk("ready_onehot", 32'($onehot(req_ready)), 1);
        if (tx_start) begin
          chk("start_while_busy", 32'(tx_busy), 0);
          chk("start_expected", 32'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("tx_data", 32'(tx_data), 32'(e[7:0]));
            chk("grant_id", 32'(grant_id), 32'(e[9:8]));
          end
          launched = tx_data;
        end else if (arb_busy) begin
          chk("tx_data_hold", 32'(tx_data), 32'(launched));
        end
        fprev = |(req_valid & req_ready);
      end else begin
        fprev = 1'b0;
      end
    end
  end

  initial begin
    int n;
    // reset with every requester asking
    rst_n     = 1'b0;
    req_valid = '1;
    req_data  = 32'hDEADBEEF;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_tx_start", 32'(tx_start), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_arb_busy", 32'(arb_busy), 0);
    chk("rst_grant_id", 32'(grant_id), 0);
    req_valid = '0;
    req_data  = '0;
    @(negedge clk);
    rst_n  = 1'b1;
    drv_en = 1'b1;

    // round-robin with all four requesters valid
    send(0, 8'h10, 1'b1); send(0, 8'h10, 1'b1);
    send(1, 8'h11, 1'b1); send(2, 8'h12, 1'b1); send(3, 8'h13, 1'b1);
    sb_push(0, 8'h10); sb_push(1, 8'h11); sb_push(2, 8'h12);
    sb_push(3, 8'h13); sb_push(0, 8'h10);
    drain("rr_drain");

    // single requester; pointer was 1 so req 2 is reached by skipping
    send(2, 8'hA5, 1'b1);
    sb_push(2, 8'hA5);
    drain("single_drain");
    chk("single_gid", 32'(grant_id), 2);

    // pointer now 3: only req 1 valid wraps through 3,0 to 1
    send(1, 8'h41, 1'b1);
    sb_push(1, 8'h41);
    drain("wrap_drain");
    // pointer now 2: 3 comes before 0
    send(3, 8'h33, 1'b1); send(0, 8'h30, 1'b1);
    sb_push(3, 8'h33); sb_push(0, 8'h30);
    drain("skip_drain");

    // clean reset so burst ordering starts at pointer 0
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk);
    chk("rst2_grant_id", 32'(grant_id), 0);
    chk("rst2_tx_data", 32'(tx_data), 0);
    rst_n = 1'b1;

    send(0, 8'h50, 1'b0); send(0, 8'h51, 1'b0); send(0, 8'h52, 1'b1);
    send(1, 8'h61, 1'b1); send(1, 8'h62, 1'b1);
`ifdef UART_ARB_BURST_EN
    sb_push(0, 8'h50); sb_push(0, 8'h51); sb_push(0, 8'h52);
    sb_push(1, 8'h61); sb_push(1, 8'h62);
`else
    sb_push(0, 8'h50); sb_push(1, 8'h61); sb_push(0, 8'h51);
    sb_push(1, 8'h62); sb_push(0, 8'h52);
`endif
    drain("burst_drain");

    // reset while the frame is in flight
    send(2, 8'h77, 1'b1);
    sb_push(2, 8'h77);
    n = 0;
    while (!(arb_busy && tx_busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("reach_wait_busy", 32'(n < 200), 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_tx_start", 32'(tx_start), 0);
    chk("midrst_arb_busy", 32'(arb_busy), 0);
    chk("midrst_ready", 32'(req_ready), 0);
    chk("midrst_tx_data", 32'(tx_data), 0);
    chk("midrst_sb_empty", 32'(exp_q.size()), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send(3, 8'h83, 1'b1); send(0, 8'h80, 1'b1);
    sb_push(0, 8'h80); sb_push(3, 8'h83);
    drain("post_rst_drain");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
